// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : alu_rr_scheduler
//  Description : Round-robin scheduler sharing one ALU datapath between two
//                requesters. It latches an op and its operands, loads the
//                ALU, captures the result and overflow, and returns a
//                response to the granted requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_scheduler #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    // requester 0
    input  logic             req0_valid,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_ovf,
    output logic             rsp0_err,
    input  logic             rsp0_ready,
    // requester 1
    input  logic             req1_valid,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_ovf,
    output logic             rsp1_err,
    input  logic             rsp1_ready,
    // ALU drive
    output logic             alu_on,
    output logic [2:0]       alu_in_sel,
    output logic [6:0]       alu_out_sel,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ovf,
    // status
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] C_OP_MULT     = 3'd6;
    localparam logic [2:0] C_OP_ILLEGAL  = 3'd7;
    localparam logic [2:0] C_SEL_RESET   = 3'b001;
    localparam logic [2:0] C_SEL_LOAD    = 3'b010;
    localparam logic [2:0] C_SEL_PERSIST = 3'b100;

    state_t             state_q, state_d;
    logic               last_q, last_d;      // requester granted most recently
    logic               gnt_q, gnt_d;        // requester owning the in-flight op
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic               on_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               w_pick;              // grantee if a grant happens now
    logic               w_rsp_ready;
    logic               w_active;
    logic [6:0]         w_out_sel;

    // Both valid: alternate away from the last grantee; otherwise take whoever asks.
    assign w_pick      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign w_rsp_ready = gnt_q ? rsp1_ready : rsp0_ready;
    assign w_active    = (state_q != S_IDLE);

    // Next-state and datapath capture for the IDLE->ISSUE->WAIT->RESP sequence.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    gnt_d   = w_pick;
                    op_d    = w_pick ? req1_op : req0_op;
                    a_d     = w_pick ? req1_a  : req0_a;
                    b_d     = w_pick ? req1_b  : req0_b;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (op_q == C_OP_ILLEGAL) begin
                    data_d  = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                data_d  = alu_result;
                ovf_d   = (op_q == C_OP_MULT) && alu_ovf;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (w_rsp_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    last_d  = gnt_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;                 // so the first contested grant goes to req0
            gnt_q   <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            on_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            on_q    <= 1'b1;
            cnt_q   <= cnt_d;
        end
    end

    // One-hot op select, held from ISSUE through RESP; op 7 selects nothing.
    always_comb begin
        w_out_sel = '0;
        if (w_active) begin
            for (int i = 0; i < 7; i++) begin
                w_out_sel[i] = (op_q == 3'(i));
            end
        end
    end

    assign alu_on      = on_q;
    assign alu_in_sel  = !on_q ? C_SEL_RESET :
                         ((state_q == S_ISSUE) && (op_q != C_OP_ILLEGAL)) ? C_SEL_LOAD :
                         C_SEL_PERSIST;
    assign alu_out_sel = w_out_sel;
    assign alu_num1    = w_active ? a_q : '0;
    assign alu_num2    = w_active ? b_q : '0;

    assign req0_ready  = (state_q == S_ISSUE) && !gnt_q;
    assign req1_ready  = (state_q == S_ISSUE) &&  gnt_q;
    assign rsp0_valid  = (state_q == S_RESP)  && !gnt_q;
    assign rsp1_valid  = (state_q == S_RESP)  &&  gnt_q;
    assign rsp0_data   = rsp0_valid ? data_q : '0;
    assign rsp0_ovf    = rsp0_valid && ovf_q;
    assign rsp0_err    = rsp0_valid && err_q;
    assign rsp1_data   = rsp1_valid ? data_q : '0;
    assign rsp1_ovf    = rsp1_valid && ovf_q;
    assign rsp1_err    = rsp1_valid && err_q;

    assign busy        = w_active;
    assign op_count    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_rr_scheduler
//  Description : Directed self-checking bench for alu_rr_scheduler with a
//                behavioural 8-bit ALU (operand DFFs + op output mux).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rr_scheduler;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic [2:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_ready, req1_ready;
    logic             rsp0_valid, rsp1_valid;
    logic [WIDTH-1:0] rsp0_data, rsp1_data;
    logic             rsp0_ovf, rsp1_ovf, rsp0_err, rsp1_err;
    logic             rsp0_ready, rsp1_ready;
    logic             alu_on;
    logic [2:0]       alu_in_sel;
    logic [6:0]       alu_out_sel;
    logic [WIDTH-1:0] alu_num1, alu_num2, alu_result;
    logic             alu_ovf;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    alu_rr_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp0_ovf(rsp0_ovf), .rsp0_err(rsp0_err), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .rsp1_ovf(rsp1_ovf), .rsp1_err(rsp1_err), .rsp1_ready(rsp1_ready),
        .alu_on(alu_on), .alu_in_sel(alu_in_sel), .alu_out_sel(alu_out_sel),
        .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_result(alu_result),
        .alu_ovf(alu_ovf), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: operand registers load on in_sel=load, clear on reset select.
    logic [WIDTH-1:0] m_a = '0, m_b = '0;
    logic [15:0]      m_prod;
    always @(posedge clk) begin
        if (alu_in_sel == 3'b010) begin
            m_a <= alu_num1;
            m_b <= alu_num2;
        end else if (alu_in_sel == 3'b001) begin
            m_a <= '0;
            m_b <= '0;
        end
    end
    // Multiplier overflow flag is raw from the multiplier, whatever op is selected.
    always_comb begin
        m_prod     = 16'(m_a) * 16'(m_b);
        alu_ovf    = (m_prod > 16'd255);
        alu_result = '0;
        case (alu_out_sel)
            7'b0000001: alu_result = m_a & m_b;
            7'b0000010: alu_result = m_a | m_b;
            7'b0000100: alu_result = ~m_a;
            7'b0001000: alu_result = m_a ^ m_b;
            7'b0010000: alu_result = m_a + m_b;
            7'b0100000: alu_result = m_a - m_b;
            7'b1000000: alu_result = m_prod[7:0];
            default:    alu_result = '0;
        endcase
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0; rsp0_ready = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0; rsp1_ready = 0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_cnt = 0;
    endtask

    // Drive one op on requester r, hold rsp_ready low for 'hold' RESP cycles, then consume.
    task automatic run_op(input bit r, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int hold, output int lat,
                          output logic [7:0] d, output logic ov, output logic er,
                          output bit to);
        int n;
        to = 0; lat = 0; d = '0; ov = 0; er = 0;
        if (r) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        else   begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        n = 0;
        do begin tick(); n++; end while (!(r ? req1_ready : req0_ready) && n < 20);
        if (r) req1_valid = 0; else req0_valid = 0;
        if (!(r ? req1_ready : req0_ready)) begin to = 1; return; end
        n = 0;
        while (!(r ? rsp1_valid : rsp0_valid) && n < 20) begin tick(); n++; end
        lat = n;
        if (!(r ? rsp1_valid : rsp0_valid)) begin to = 1; return; end
        d  = r ? rsp1_data : rsp0_data;
        ov = r ? rsp1_ovf  : rsp0_ovf;
        er = r ? rsp1_err  : rsp0_err;
        repeat (hold) tick();
        if (r) rsp1_ready = 1; else rsp0_ready = 1;
        tick();
        rsp0_ready = 0; rsp1_ready = 0;
        exp_cnt = (exp_cnt + 1) % 16;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({alu_on, alu_in_sel, alu_out_sel, busy, op_count, rsp0_valid, rsp1_valid} !== {1'b0, 3'b001, 7'd0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: on=%b in_sel=%b out_sel=%b busy=%b cnt=%0d v0=%b v1=%b, required 0 001 0000000 0 0 0 0",
                     alu_on, alu_in_sel, alu_out_sel, busy, op_count, rsp0_valid, rsp1_valid);
        end
        tick();
        checks++;
        if (alu_on !== 1'b1 || alu_in_sel !== 3'b100 || alu_num1 !== 8'd0) begin
            failures++;
            $display("FAIL post_reset: on=%b in_sel=%b num1=%0d, required 1 100 0", alu_on, alu_in_sel, alu_num1);
        end
    endtask

    task automatic test_single();
        req0_valid = 1; req0_op = 3'd4; req0_a = 8'd20; req0_b = 8'd22;
        tick();
        checks++;
        if (req0_ready !== 1 || req1_ready !== 0 || alu_in_sel !== 3'b010 || alu_out_sel !== 7'b0010000 ||
            alu_num1 !== 8'd20 || alu_num2 !== 8'd22 || busy !== 1) begin
            failures++;
            $display("FAIL single_issue: rdy0=%b rdy1=%b in_sel=%b out_sel=%b n1=%0d n2=%0d busy=%b, required 1 0 010 0010000 20 22 1",
                     req0_ready, req1_ready, alu_in_sel, alu_out_sel, alu_num1, alu_num2, busy);
        end
        req0_valid = 0; req0_a = 8'd99;
        tick();
        checks++;
        if (req0_ready !== 0 || rsp0_valid !== 0 || alu_in_sel !== 3'b100 || alu_num1 !== 8'd20 || alu_out_sel !== 7'b0010000) begin
            failures++;
            $display("FAIL single_wait: rdy0=%b v0=%b in_sel=%b n1=%0d out_sel=%b, required 0 0 100 20 0010000",
                     req0_ready, rsp0_valid, alu_in_sel, alu_num1, alu_out_sel);
        end
        tick();
        checks++;
        if (rsp0_valid !== 1 || rsp0_data !== 8'd42 || rsp0_ovf !== 0 || rsp0_err !== 0 || rsp1_valid !== 0) begin
            failures++;
            $display("FAIL single_resp: v0=%b data=%0d ovf=%b err=%b v1=%b, required 1 42 0 0 0",
                     rsp0_valid, rsp0_data, rsp0_ovf, rsp0_err, rsp1_valid);
        end
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        exp_cnt++;
        checks++;
        if (rsp0_valid !== 0 || busy !== 0 || op_count !== 4'(exp_cnt) || alu_num1 !== 0 || alu_out_sel !== 0) begin
            failures++;
            $display("FAIL single_done: v0=%b busy=%b cnt=%0d n1=%0d out_sel=%b, required 0 0 %0d 0 0",
                     rsp0_valid, busy, op_count, alu_num1, alu_out_sel, exp_cnt);
        end
    endtask

    task automatic test_arbitration();
        int g;
        int grant[4];
        int gcyc[4];
        int bad;
        apply_reset();
        tick();
        g = 0; bad = 0;
        req0_valid = 1; req0_op = 3'd0; req0_a = 8'hF0; req0_b = 8'h3C;
        req1_valid = 1; req1_op = 3'd1; req1_a = 8'hF0; req1_b = 8'h3C;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int c = 0; c < 80 && (g < 4 || busy); c++) begin
            tick();
            if (req0_ready && req1_ready) bad++;
            if (rsp0_valid && rsp1_valid) bad++;
            if (g < 4 && (req0_ready || req1_ready)) begin
                grant[g] = req1_ready ? 1 : 0;
                gcyc[g]  = c;
                g++;
                if (g == 4) begin req0_valid = 0; req1_valid = 0; end
            end
            if (rsp0_valid) begin
                exp_cnt++;
                if (rsp0_data !== 8'h30) bad++;
            end
            if (rsp1_valid) begin
                exp_cnt++;
                if (rsp1_data !== 8'hFC) bad++;
            end
        end
        rsp0_ready = 0; rsp1_ready = 0;
        checks++;
        if (g != 4 || grant[0] != 0 || grant[1] != 1 || grant[2] != 0 || grant[3] != 1) begin
            failures++;
            $display("FAIL arb_order: grants=%0d order=%0d%0d%0d%0d, required 4 grants order 0101",
                     g, grant[0], grant[1], grant[2], grant[3]);
        end
        checks++;
        if (g == 4 && gcyc[3] - gcyc[0] != 12) begin
            failures++;
            $display("FAIL arb_throughput: cycles first-to-fourth grant=%0d, required 12", gcyc[3] - gcyc[0]);
        end
        checks++;
        if (bad != 0 || op_count !== 4'(exp_cnt) || exp_cnt != 4) begin
            failures++;
            $display("FAIL arb_responses: errors=%0d cnt=%0d seen=%0d, required 0 errors cnt 4 seen 4", bad, op_count, exp_cnt);
        end
    endtask

    task automatic test_overflow();
        int lat; logic [7:0] d; logic ov, er; bit to;
        logic [2:0]  t_op[6]  = '{3'd6, 3'd4, 3'd4, 3'd5, 3'd3, 3'd2};
        logic [7:0]  t_a[6]   = '{8'd16, 8'd255, 8'd200, 8'd5, 8'hAA, 8'h0F};
        logic [7:0]  t_b[6]   = '{8'd16, 8'd1, 8'd100, 8'd7, 8'h0F, 8'h55};
        logic [7:0]  t_d[6]   = '{8'd0, 8'd0, 8'd44, 8'hFE, 8'hA5, 8'hF0};
        logic        t_ov[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        bit          t_r[6]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            run_op(t_r[i], t_op[i], t_a[i], t_b[i], 0, lat, d, ov, er, to);
            checks++;
            if (to || d !== t_d[i] || ov !== t_ov[i] || er !== 1'b0 || lat != 2) begin
                failures++;
                $display("FAIL ovf_vec%0d: timeout=%0d data=%0d ovf=%b err=%b lat=%0d, required 0 %0d %b 0 2",
                         i, to, d, ov, er, lat, t_d[i], t_ov[i]);
            end
        end
        checks++;
        if (op_count !== 4'(exp_cnt)) begin
            failures++;
            $display("FAIL ovf_count: cnt=%0d, required %0d", op_count, exp_cnt);
        end
    endtask

    task automatic test_illegal_backpressure();
        int held_bad;
        req0_valid = 1; req0_op = 3'd7; req0_a = 8'd5; req0_b = 8'd6;
        tick();
        checks++;
        if (req0_ready !== 1 || alu_in_sel !== 3'b100 || alu_out_sel !== 7'd0) begin
            failures++;
            $display("FAIL illegal_issue: rdy0=%b in_sel=%b out_sel=%b, required 1 100 0000000",
                     req0_ready, alu_in_sel, alu_out_sel);
        end
        req0_valid = 0;
        req1_valid = 1; req1_op = 3'd4; req1_a = 8'd1; req1_b = 8'd2;
        tick();
        checks++;
        if (rsp0_valid !== 1 || rsp0_err !== 1 || rsp0_data !== 8'd0 || rsp0_ovf !== 0) begin
            failures++;
            $display("FAIL illegal_resp: v0=%b err=%b data=%0d ovf=%b, required 1 1 0 0",
                     rsp0_valid, rsp0_err, rsp0_data, rsp0_ovf);
        end
        held_bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp0_valid !== 1 || rsp0_err !== 1 || rsp0_data !== 0 || req1_ready !== 0 ||
                rsp1_valid !== 0 || busy !== 1) held_bad++;
        end
        checks++;
        if (held_bad != 0) begin
            failures++;
            $display("FAIL backpressure_hold: bad cycles=%0d, required 0", held_bad);
        end
        rsp0_ready = 1;
        tick();
        rsp0_ready = 0;
        exp_cnt++;
        checks++;
        if (rsp0_valid !== 0 || op_count !== 4'(exp_cnt)) begin
            failures++;
            $display("FAIL illegal_consume: v0=%b cnt=%0d, required 0 %0d", rsp0_valid, op_count, exp_cnt);
        end
        tick();
        checks++;
        if (req1_ready !== 1) begin
            failures++;
            $display("FAIL held_request: rdy1=%b, required 1", req1_ready);
        end
        req1_valid = 0;
        tick(); tick();
        checks++;
        if (rsp1_valid !== 1 || rsp1_data !== 8'd3 || rsp1_err !== 0) begin
            failures++;
            $display("FAIL held_result: v1=%b data=%0d err=%b, required 1 3 0", rsp1_valid, rsp1_data, rsp1_err);
        end
        rsp1_ready = 1;
        tick();
        rsp1_ready = 0;
        exp_cnt++;
    endtask

    task automatic test_reset_mid_resp();
        req0_valid = 1; req0_op = 3'd4; req0_a = 8'd1; req0_b = 8'd1;
        tick();
        req0_valid = 0;
        tick(); tick();
        checks++;
        if (rsp0_valid !== 1 || op_count === 4'd0) begin
            failures++;
            $display("FAIL midreset_setup: v0=%b cnt=%0d, required 1 and nonzero", rsp0_valid, op_count);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rsp0_valid !== 0 || busy !== 0 || alu_in_sel !== 3'b001 || op_count !== 0 ||
            alu_on !== 0 || alu_num1 !== 0 || rsp0_data !== 0) begin
            failures++;
            $display("FAIL midreset_async: v0=%b busy=%b in_sel=%b cnt=%0d on=%b n1=%0d data=%0d, required 0 0 001 0 0 0 0",
                     rsp0_valid, busy, alu_in_sel, op_count, alu_on, alu_num1, rsp0_data);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_cnt = 0;
        tick(); tick();
        checks++;
        if (rsp0_valid !== 0 || busy !== 0) begin
            failures++;
            $display("FAIL midreset_dropped: v0=%b busy=%b, required 0 0", rsp0_valid, busy);
        end
    endtask

    task automatic test_counter();
        int lat; logic [7:0] d; logic ov, er; bit to;
        int tos;
        apply_reset();
        tick();
        tos = 0;
        for (int i = 0; i < 15; i++) begin
            run_op(i[0], 3'd4, 8'(i), 8'd1, 0, lat, d, ov, er, to);
            if (to || d !== 8'(i + 1)) tos++;
        end
        checks++;
        if (tos != 0 || op_count !== 4'd15) begin
            failures++;
            $display("FAIL counter_preload: errors=%0d cnt=%0d, required 0 15", tos, op_count);
        end
        run_op(1'b0, 3'd7, 8'd0, 8'd0, 0, lat, d, ov, er, to);
        checks++;
        if (to || er !== 1 || lat != 1 || op_count !== 4'd0) begin
            failures++;
            $display("FAIL counter_wrap: timeout=%0d err=%b lat=%0d cnt=%0d, required 0 1 1 0", to, er, lat, op_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_overflow();
        test_illegal_backpressure();
        test_reset_mid_resp();
        test_counter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
